dcache_qspi_xfer: RTL and testbench
===================================

// Module: dcache_qspi_xfer
// PURPOSE
//  Memory-side line transfer engine for dcache: services fill (pull) and writeback (push) requests
//  by running QSPI PSRAM read/write bursts and streaming nibbles to/from the cache line port.
//  Drives dread/wstrobe_d for fills; consumes dwrite via rstrobe_d for writebacks. Sits between
//  dcache and the QSPI pad ring; busy stalls the core while a transfer is in flight.
// PARAMETERS
//  PA           22  physical address width (bits)
//  LINE_LENGTH  4   cache line length in bytes; a line is 2*LINE_LENGTH nibbles
//  READ_DUMMY   6   dummy SCK cycles between address and read data
//  CS_HIGH      2   minimum clk cycles qspi_cs_n held high between bursts
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  op_valid     in   1   core has a memory op this cycle; qualifies push/pull
//  push         in   1   cache needs dirty line written back
//  pull         in   1   cache needs line filled
//  line_tag     in   PA-$clog2(LINE_LENGTH)  line address; sampled at start of each burst
//  busy         out  1   transfer in progress (request accepted through done)
//  done         out  1   one-cycle pulse: all requested bursts complete
//  dread        out  4   fill nibble to cache
//  wstrobe_d    out  1   dread valid; cache writes nibble and advances its offset
//  dwrite       in   4   writeback nibble presented by cache at its current offset
//  rstrobe_d    out  1   dwrite consumed; cache advances its offset
//  qspi_cs_n    out  1   chip select, active low
//  qspi_sck_en  out  1   SCK gate; pad logic forms SCK = clk & qspi_sck_en
//  qspi_dout    out  4   IO[3:0] output data
//  qspi_oe      out  4   IO[3:0] output enables
//  qspi_din     in   4   IO[3:0] input data
// BEHAVIOUR
//  Reset: busy=0, done=0, wstrobe_d=0, rstrobe_d=0, dread=0, qspi_cs_n=1, qspi_sck_en=0,
//   qspi_dout=0, qspi_oe=0; FSM->IDLE. Reset mid-burst aborts it: cs_n high next cycle, no strobes.
//  Accept in IDLE when op_valid && (push||pull): busy=1 next cycle. push&&pull -> writeback burst,
//   CS_HIGH gap, then fill burst. op_valid/push/pull ignored once accepted.
//  FSM: IDLE -> CMD -> ADDR -> (read: DUMMY) -> DATA -> GAP -> next burst CMD or IDLE(done=1).
//  CMD: 8-bit command, write 0x38, read 0xEB, MSB first. ADDR: 24 bits = {zero pad, line_tag,
//   $clog2(LINE_LENGTH) zeros}, 6 nibbles quad, MSN first. DUMMY: READ_DUMMY cycles, oe=0.
//  DATA: exactly 2*LINE_LENGTH SCK cycles, one nibble per clk, no gaps; the cache offset resets
//   on any strobe-free cycle, so wstrobe_d/rstrobe_d MUST be high on 2*LINE_LENGTH consecutive
//   cycles and never otherwise.
//  Read: qspi_din registered; wstrobe_d high on cycles 1..2*LINE_LENGTH after first data SCK,
//   dread = registered nibble, arrival order (high nibble of byte 0 first).
//  Write: rstrobe_d high 2*LINE_LENGTH consecutive cycles starting the cycle before first data SCK;
//   each dwrite registered into qspi_dout, shifted out next cycle with oe=4'hF.
//  GAP: cs_n=1, sck_en=0 for CS_HIGH cycles. done pulses in the cycle busy falls.
//  Counters: phase counter width $clog2(max(8,2*LINE_LENGTH,READ_DUMMY)+1); no wrap within a phase.
// CONFIGURATION
//  QSPI_CMD_QUAD_EN defined: command sent quad (QPI), 2 cycles, oe=4'hF.
//  Undefined: command sent SPI on IO0, 8 cycles, oe=4'b0001; addr/dummy/data quad either way.
// STRUCTURE
//  dcache_pkg: state enum (IDLE,CMD,ADDR,DUMMY,DATA,GAP), QSPI_CMD_READ=8'hEB,
//   QSPI_CMD_WRITE=8'h38, ADDR_NIBBLES=6.
//  Sub-module qspi_nibble_io: registered dout/oe/sck_en/cs_n outputs and din capture register.
// TESTING
//  Pull only, line_tag=20'h12345, PSRAM model returns 8'h12,34,56,78 -> cmd EB, addr 0x048D14,
//   6 dummy, wstrobe_d high exactly 8 consecutive cycles, dread 1,2,3,4,5,6,7,8, done once.
//  Push only, cache line 32'hDEADBEEF -> cmd 38, rstrobe_d 8 consecutive cycles, model stores
//   bytes EF,BE,AD,DE at line address; no wstrobe_d.
//  push&&pull same cycle -> write burst, cs_n high >=2 cycles, read burst, single done; busy unbroken.
//  op_valid=0 with pull=1 -> no request accepted, cs_n stays 1, busy 0.
//  Reset asserted in DATA after 3 fill nibbles -> next cycle cs_n=1, wstrobe_d=0, busy=0; new pull
//   then completes normally with 8 strobes.
//  Build with and without QSPI_CMD_QUAD_EN -> CMD phase 2 vs 8 SCK cycles, oe 4'hF vs 4'b0001.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache QSPI PSRAM line transfer engine.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } xfer_state_e;

  localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
  localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;
  localparam int         ADDR_NIBBLES   = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcache_qspi_xfer_nibble_io.sv
// QSPI pad-side register stage: registered cs_n/sck_en/dout/oe toward the pads
// and a capture register for the incoming IO nibble.
module qspi_nibble_io (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n_i,
  input  logic       sck_en_i,
  input  logic [3:0] dout_i,
  input  logic [3:0] oe_i,
  input  logic [3:0] din_i,
  output logic       cs_n_o,
  output logic       sck_en_o,
  output logic [3:0] dout_o,
  output logic [3:0] oe_o,
  output logic [3:0] din_o
);

  logic       cs_n_q;
  logic       sck_en_q;
  logic [3:0] dout_q;
  logic [3:0] oe_q;
  logic [3:0] din_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_q   <= 1'b1;
      sck_en_q <= 1'b0;
      dout_q   <= 4'h0;
      oe_q     <= 4'h0;
      din_q    <= 4'h0;
    end else begin
      cs_n_q   <= cs_n_i;
      sck_en_q <= sck_en_i;
      dout_q   <= dout_i;
      oe_q     <= oe_i;
      din_q    <= din_i;
    end
  end

  assign cs_n_o   = cs_n_q;
  assign sck_en_o = sck_en_q;
  assign dout_o   = dout_q;
  assign oe_o     = oe_q;
  assign din_o    = din_q;

endmodule

// File: rtl/dcache_qspi_xfer.sv
// dcache line fill/writeback engine running QSPI PSRAM bursts.
// Build option: QSPI_CMD_QUAD_EN sends the command byte in quad (QPI) mode.
//
// state | meaning
// IDLE  | waiting for op_valid && (push || pull)
// CMD   | shifting out the command byte
// ADDR  | six address nibbles, MSN first
// DUMMY | read turnaround, IO released
// DATA  | one line nibble per clk, strobing the cache
// GAP   | chip select held high before next burst or done
module dcache_qspi_xfer
  import dcache_pkg::*;
#(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int READ_DUMMY  = 6,
  parameter int CS_HIGH     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              op_valid,
  input  logic                              push,
  input  logic                              pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] line_tag,
  output logic                              busy,
  output logic                              done,
  output logic [3:0]                        dread,
  output logic                              wstrobe_d,
  input  logic [3:0]                        dwrite,
  output logic                              rstrobe_d,
  output logic                              qspi_cs_n,
  output logic                              qspi_sck_en,
  output logic [3:0]                        qspi_dout,
  output logic [3:0]                        qspi_oe,
  input  logic [3:0]                        qspi_din
);

  localparam int OFS_W = $clog2(LINE_LENGTH);
  localparam int NIBS  = 2 * LINE_LENGTH;
  localparam int CW    = $clog2(max3(8, NIBS, READ_DUMMY) + 1);
`ifdef QSPI_CMD_QUAD_EN
  localparam int         CMD_CYC = 2;
  localparam logic [3:0] CMD_OE  = 4'hF;
`else
  localparam int         CMD_CYC = 8;
  localparam logic [3:0] CMD_OE  = 4'b0001;
`endif
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_NIBBLES - 1);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(READ_DUMMY - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(NIBS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_HIGH - 1);

  xfer_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          pend_rd_q, pend_rd_d;
  logic [23:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          rd_sck_q, rd_sck_d;
  logic          wstrobe_q;
  logic          rstrobe_c;
  logic          cs_n_d, sck_en_d;
  logic [3:0]    dout_d, oe_d;
  logic [7:0]    cmd;
  logic [23:0]   line_addr;

  assign cmd       = rd_q ? QSPI_CMD_READ : QSPI_CMD_WRITE;
  assign line_addr = 24'({line_tag, {OFS_W{1'b0}}});

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    rd_d      = rd_q;
    pend_rd_d = pend_rd_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    rd_sck_d  = 1'b0;
    rstrobe_c = 1'b0;
    cs_n_d    = 1'b1;
    sck_en_d  = 1'b0;
    dout_d    = 4'h0;
    oe_d      = 4'h0;
    case (state_q)
      IDLE: begin
        if (op_valid && (push || pull)) begin
          // a combined request writes the dirty line back before filling
          state_d   = CMD;
          cnt_d     = CMD_LAST;
          rd_d      = !push;
          pend_rd_d = push && pull;
          addr_d    = line_addr;
        end
      end
      CMD: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        oe_d     = CMD_OE;
`ifdef QSPI_CMD_QUAD_EN
        dout_d   = cmd[{cnt_q[0], 2'b00} +: 4];
`else
        dout_d   = {3'b000, cmd[cnt_q[2:0]]};
`endif
        if (cnt_q == '0) begin
          state_d = ADDR;
          cnt_d   = ADDR_LAST;
        end
      end
      ADDR: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        oe_d     = 4'hF;
        dout_d   = addr_q[{cnt_q[2:0], 2'b00} +: 4];
        if (cnt_q == '0) begin
          state_d = rd_q ? DUMMY : DATA;
          cnt_d   = rd_q ? DUMMY_LAST : DATA_LAST;
        end
      end
      DUMMY: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LAST;
        end
      end
      DATA: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        if (rd_q) begin
          rd_sck_d = 1'b1;
        end else begin
          // the cache presents the nibble now; it leaves on the pads next cycle
          rstrobe_c = 1'b1;
          dout_d    = dwrite;
          oe_d      = 4'hF;
        end
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LAST;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_rd_q) begin
            state_d   = CMD;
            cnt_d     = CMD_LAST;
            rd_d      = 1'b1;
            pend_rd_d = 1'b0;
            addr_d    = line_addr;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      pend_rd_q <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      rd_sck_q  <= 1'b0;
      wstrobe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      pend_rd_q <= pend_rd_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      rd_sck_q  <= rd_sck_d;
      // strobe trails the read SCK by the din capture register
      wstrobe_q <= rd_sck_q;
    end
  end

  qspi_nibble_io u_io (
    .clk      (clk),
    .reset    (reset),
    .cs_n_i   (cs_n_d),
    .sck_en_i (sck_en_d),
    .dout_i   (dout_d),
    .oe_i     (oe_d),
    .din_i    (qspi_din),
    .cs_n_o   (qspi_cs_n),
    .sck_en_o (qspi_sck_en),
    .dout_o   (qspi_dout),
    .oe_o     (qspi_oe),
    .din_o    (dread)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign wstrobe_d = wstrobe_q;
  assign rstrobe_d = rstrobe_c;

endmodule

// File: tb/tb_dcache_qspi_xfer.sv
// Scoreboard bench for dcache_qspi_xfer with a behavioural QSPI PSRAM and cache line model.
module tb_dcache_qspi_xfer;

  localparam int LL      = 4;
  localparam int NIBS    = 2 * LL;
  localparam int DUMMY_N = 6;
  localparam int CS_HI   = 2;
`ifdef QSPI_CMD_QUAD_EN
  localparam int         CMD_CYC = 2;
  localparam logic [3:0] CMD_OE  = 4'hF;
`else
  localparam int         CMD_CYC = 8;
  localparam logic [3:0] CMD_OE  = 4'b0001;
`endif

  logic        clk;
  logic        reset;
  logic        op_valid, push, pull;
  logic [19:0] line_tag;
  logic        busy, done, wstrobe_d, rstrobe_d;
  logic [3:0]  dread, dwrite;
  logic        qspi_cs_n, qspi_sck_en;
  logic [3:0]  qspi_dout, qspi_oe, qspi_din;

  dcache_qspi_xfer dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .push        (push),
    .pull        (pull),
    .line_tag    (line_tag),
    .busy        (busy),
    .done        (done),
    .dread       (dread),
    .wstrobe_d   (wstrobe_d),
    .dwrite      (dwrite),
    .rstrobe_d   (rstrobe_d),
    .qspi_cs_n   (qspi_cs_n),
    .qspi_sck_en (qspi_sck_en),
    .qspi_dout   (qspi_dout),
    .qspi_oe     (qspi_oe),
    .qspi_din    (qspi_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nd;
  } burst_t;

  burst_t     exp_b[$];
  logic [3:0] exp_rd[$];
  int         exp_done[$];
  int         done_cnt = 0;
  int         rd_seen = 0;

  // cache line source for writebacks: offset advances on rstrobe, clears otherwise
  logic [31:0] cache_line;
  int          off = 0;
  always @(posedge clk) off <= rstrobe_d ? off + 1 : 0;
  always_comb begin
    dwrite = 4'h0;
    if (off < NIBS) dwrite = cache_line[(off / 2) * 8 + ((off % 2 == 0) ? 4 : 0) +: 4];
  end

  // PSRAM model, sampling the pads on the falling edge
  bit [7:0]    mem[int];
  int          m_sck = 0, m_nd = 0, m_high = 100, k, d;
  logic        m_prev_cs = 1'b1;
  logic        m_oe_bad = 1'b0;
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_addr = 24'h0;
  logic [7:0]  b;
  burst_t      e;

  always @(negedge clk) begin
    if (qspi_cs_n !== 1'b0) begin
      if (m_prev_cs === 1'b0) begin
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL burst_unexpected got cmd=%0h expected none", m_cmd);
        end else begin
          e = exp_b.pop_front();
          chk("burst_cmd", 32'(m_cmd), 32'(e.cmd));
          chk("burst_addr", 32'(m_addr), 32'(e.addr));
          chk("burst_oe_ok", 32'(m_oe_bad), 32'h0);
          if (e.nd >= 0) chk("burst_data_sck", m_nd, e.nd);
        end
      end
      m_high++; m_sck = 0; m_nd = 0; m_oe_bad = 1'b0;
      qspi_din = 4'h0;
    end else begin
      if (m_prev_cs !== 1'b0) begin
        checks++;
        if (m_high < CS_HI) begin
          failures++;
          $display("FAIL cs_high_gap got=%0d expected>=%0d", m_high, CS_HI);
        end
        m_high = 0;
      end
      if (qspi_sck_en) begin
        if (m_sck < CMD_CYC) begin
`ifdef QSPI_CMD_QUAD_EN
          m_cmd = {m_cmd[3:0], qspi_dout};
`else
          m_cmd = {m_cmd[6:0], qspi_dout[0]};
`endif
          if (qspi_oe !== CMD_OE) m_oe_bad = 1'b1;
        end else if (m_sck < CMD_CYC + 6) begin
          m_addr = {m_addr[19:0], qspi_dout};
          if (qspi_oe !== 4'hF) m_oe_bad = 1'b1;
        end else begin
          k = m_sck - CMD_CYC - 6;
          if (m_cmd == 8'hEB) begin
            if (qspi_oe !== 4'h0) m_oe_bad = 1'b1;
            if (k < DUMMY_N) begin
              qspi_din = 4'h0;
            end else begin
              d = k - DUMMY_N;
              b = mem[int'(m_addr) + d / 2];
              qspi_din = (d % 2 == 0) ? b[7:4] : b[3:0];
              m_nd++;
            end
          end else begin
            if (qspi_oe !== 4'hF) m_oe_bad = 1'b1;
            b = mem[int'(m_addr) + k / 2];
            mem[int'(m_addr) + k / 2] = (k % 2 == 0) ? {qspi_dout, b[3:0]} : {b[7:4], qspi_dout};
            m_nd++;
          end
        end
        m_sck++;
      end
    end
    m_prev_cs = qspi_cs_n;
  end

  // scoreboard monitor
  int   w_run = 0, r_run = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      w_run = 0; r_run = 0; prev_busy = 1'b0;
    end else begin
      if (wstrobe_d) begin
        w_run++; rd_seen++;
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL wstrobe_unexpected got dread=%0h expected no strobe", dread);
        end else chk("dread", 32'(dread), 32'(exp_rd.pop_front()));
      end else if (w_run > 0) begin
        chk("wstrobe_run", w_run, NIBS);
        w_run = 0;
      end
      if (rstrobe_d) r_run++;
      else if (r_run > 0) begin
        chk("rstrobe_run", r_run, NIBS);
        r_run = 0;
      end
      chk("strobes_exclusive", 32'(wstrobe_d & rstrobe_d), 32'h0);
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected got=1 expected=0");
        end else void'(exp_done.pop_front());
        chk("done_busy_low", 32'(busy), 32'h0);
      end
      if (prev_busy && !busy) chk("done_at_busy_fall", 32'(done), 32'h1);
      prev_busy = busy;
    end
  end

  task automatic push_nibs(input logic [31:0] v);
    for (int i = 7; i >= 0; i--) exp_rd.push_back(v[i*4 +: 4]);
  endtask

  task automatic req(input logic p, input logic l, input logic [19:0] tag);
    @(negedge clk); #1;
    line_tag = tag; push = p; pull = l; op_valid = 1'b1;
    @(negedge clk); #1;
    op_valid = 1'b0; push = 1'b0; pull = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < 300 && done_cnt == start; i++) @(negedge clk);
    checks++;
    if (done_cnt == start) begin
      failures++;
      $display("FAIL %s_timeout got no done expected done within 300 cycles", name);
    end
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_burst_left"}, exp_b.size(), 0);
    chk({name, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b1; op_valid = 1'b0; push = 1'b0; pull = 1'b0;
    line_tag = 20'h0; cache_line = 32'h0; qspi_din = 4'h0;
    mem[32'h048D14] = 8'h12; mem[32'h048D15] = 8'h34;
    mem[32'h048D16] = 8'h56; mem[32'h048D17] = 8'h78;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wstrobe", 32'(wstrobe_d), 0);
    chk("rst_rstrobe", 32'(rstrobe_d), 0);
    chk("rst_dread", 32'(dread), 0);
    chk("rst_cs_n", 32'(qspi_cs_n), 1);
    chk("rst_sck_en", 32'(qspi_sck_en), 0);
    chk("rst_dout", 32'(qspi_dout), 0);
    chk("rst_oe", 32'(qspi_oe), 0);

    // fill only
    exp_b.push_back('{8'hEB, 24'h048D14, NIBS});
    push_nibs(32'h12345678);
    exp_done.push_back(1);
    req(1'b0, 1'b1, 20'h12345);
    chk("busy_after_accept", 32'(busy), 1);
    wait_done("pull");

    // writeback only
    cache_line = 32'hDEADBEEF;
    exp_b.push_back('{8'h38, 24'h02AF34, NIBS});
    exp_done.push_back(1);
    req(1'b1, 1'b0, 20'h0ABCD);
    wait_done("push");
    chk("wb_byte0", 32'(mem[32'h02AF34]), 32'hEF);
    chk("wb_byte1", 32'(mem[32'h02AF35]), 32'hBE);
    chk("wb_byte2", 32'(mem[32'h02AF36]), 32'hAD);
    chk("wb_byte3", 32'(mem[32'h02AF37]), 32'hDE);

    // writeback then fill of the same line in one request
    cache_line = 32'h0BADF00D;
    exp_b.push_back('{8'h38, 24'h000400, NIBS});
    exp_b.push_back('{8'hEB, 24'h000400, NIBS});
    push_nibs(32'h0DF0AD0B);
    exp_done.push_back(1);
    req(1'b1, 1'b1, 20'h00100);
    wait_done("push_pull");

    // request without op_valid is ignored
    @(negedge clk); #1;
    pull = 1'b1; op_valid = 1'b0; line_tag = 20'h12345;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("nv_busy", 32'(busy), 0);
      chk("nv_cs_n", 32'(qspi_cs_n), 1);
    end
    pull = 1'b0;

    // reset in the middle of a fill
    exp_b.push_back('{8'hEB, 24'h048D14, -1});
    push_nibs(32'h12345678);
    start = rd_seen;
    req(1'b0, 1'b1, 20'h12345);
    for (int i = 0; i < 200 && rd_seen - start < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached_3_nibbles", rd_seen - start, 3);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_cs_n", 32'(qspi_cs_n), 1);
    chk("abort_wstrobe", 32'(wstrobe_d), 0);
    chk("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    exp_rd.delete();
    @(negedge clk); #1;
    chk("abort_burst_closed", exp_b.size(), 0);

    exp_b.push_back('{8'hEB, 24'h048D14, NIBS});
    push_nibs(32'h12345678);
    exp_done.push_back(1);
    req(1'b0, 1'b1, 20'h12345);
    wait_done("pull_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
